// File: rtl/read_reply_router.sv
// Tagged in-order reply router: tracks up to DEPTH outstanding reads from NCH
// requesters and steers each RX reply back to its issuer. Define RR_ARBITER_EN
// for round-robin arbitration; otherwise the lowest requesting index wins.
module read_reply_router #(
  parameter int NCH   = 2,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(NCH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCH-1:0]             ch_req,
  output logic [NCH-1:0]             ch_grant,
  output logic                       tx_command_valid,
  input  logic                       tx_command_started,
  input  logic                       rx_started,
  input  logic                       rx_data_valid,
  input  logic                       rx_done,
  input  logic                       flush,
  output logic [NCH-1:0]             ch_rx_valid,
  output logic [NCH-1:0]             ch_rx_done,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       full,
  output logic                       empty,
  output logic                       error
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef enum logic {TX_UNLOCKED, TX_LOCKED} tx_state_e;
  typedef enum logic {RX_IDLE, RX_BUSY} rx_state_e;

  tx_state_e tx_q, tx_next;
  rx_state_e rx_q, rx_next;

  logic [CW-1:0]    sel_q, sel, arb_sel, cand;
  logic             found;
  logic             push, pop, dec;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [OW-1:0]    count_q;
  logic [CW-1:0]    id_mem [DEPTH];
  logic [DEPTH-1:0] keep_mem;
  logic [CW-1:0]    cur_id;
  logic             cur_keep;

`ifdef RR_ARBITER_EN
  logic [CW-1:0] rr_ptr;
`endif

  assign full        = (count_q == OW'(DEPTH));
  assign empty       = (count_q == '0);
  assign outstanding = count_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    arb_sel = '0;
    cand    = '0;
    found   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
`ifdef RR_ARBITER_EN
      cand = CW'((int'(rr_ptr) + k) % NCH);
`else
      cand = CW'(k);
`endif
      if (!found && ch_req[cand]) begin
        arb_sel = cand;
        found   = 1'b1;
      end
    end
  end

  // A locked offer keeps its channel even if that channel drops its request.
  always_comb begin
    tx_next          = tx_q;
    sel              = (tx_q == TX_LOCKED) ? sel_q : arb_sel;
    tx_command_valid = ~full & ((tx_q == TX_LOCKED) | (|ch_req));
    push             = tx_command_valid & tx_command_started;
    ch_grant         = push ? (NCH'(1) << sel) : '0;
    unique case (tx_q)
      TX_UNLOCKED: if (tx_command_valid && !tx_command_started) tx_next = TX_LOCKED;
      TX_LOCKED:   if (tx_command_started || flush) tx_next = TX_UNLOCKED;
      default:     tx_next = TX_UNLOCKED;
    endcase
  end

  always_comb begin
    rx_next     = rx_q;
    pop         = rx_started & (count_q != '0);
    dec         = rx_done & (rx_q == RX_BUSY);
    ch_rx_valid = '0;
    ch_rx_done  = '0;
    if (rx_q == RX_BUSY && cur_keep) begin
      if (rx_data_valid) ch_rx_valid = NCH'(1) << cur_id;
      if (rx_done)       ch_rx_done  = NCH'(1) << cur_id;
    end
    if (pop)      rx_next = RX_BUSY;
    else if (dec) rx_next = RX_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q    <= TX_UNLOCKED;
      rx_q    <= RX_IDLE;
      sel_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      error   <= 1'b0;
`ifdef RR_ARBITER_EN
      rr_ptr  <= '0;
`endif
    end else begin
      tx_q <= tx_next;
      rx_q <= rx_next;
      if (tx_q == TX_UNLOCKED) sel_q <= arb_sel;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, dec})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (rx_started && count_q == '0) error <= 1'b1;
`ifdef RR_ARBITER_EN
      if (push) rr_ptr <= (sel == CW'(NCH-1)) ? '0 : sel + 1'b1;
`endif
    end
  end

  // NOTE: queue storage has no reset; entries are only read after a push wrote them.
  always_ff @(posedge clk) begin
    if (flush) keep_mem <= '0;
    if (push) begin
      id_mem[wr_ptr]   <= sel;
      keep_mem[wr_ptr] <= 1'b1;
    end
    if (pop) begin
      cur_id   <= id_mem[rd_ptr];
      cur_keep <= keep_mem[rd_ptr] & ~flush;
    end else if (flush) begin
      cur_keep <= 1'b0;
    end
  end

endmodule

// File: tb/tb_read_reply_router.sv
// Table-driven bench for read_reply_router (NCH=2, DEPTH=2) plus hand-written
// multi-cycle sequences; honours RR_ARBITER_EN for the arbitration vectors.
module tb_read_reply_router;

`ifdef RR_ARBITER_EN
  localparam logic [1:0] R = 2'b10;
`else
  localparam logic [1:0] R = 2'b01;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ch_req, ch_grant, ch_rx_valid, ch_rx_done;
  logic       tx_command_valid, tx_command_started;
  logic       rx_started, rx_data_valid, rx_done, flush;
  logic [1:0] outstanding;
  logic       full, empty, error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  read_reply_router #(.NCH(2), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_grant(ch_grant),
    .tx_command_valid(tx_command_valid), .tx_command_started(tx_command_started),
    .rx_started(rx_started), .rx_data_valid(rx_data_valid), .rx_done(rx_done),
    .flush(flush), .ch_rx_valid(ch_rx_valid), .ch_rx_done(ch_rx_done),
    .outstanding(outstanding), .full(full), .empty(empty), .error(error)
  );

  typedef struct packed {
    logic [1:0] req;
    logic       st, rs, rv, rd, fl, rst;
    logic [1:0] g;
    logic       v;
    logic [1:0] cv, cd, o;
    logic       fu, em, er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] req, logic st, rs, rv, rd, fl, rst,
                              logic [1:0] g, logic v, logic [1:0] cv, cd, o,
                              logic fu, em, er);
    vec_t t;
    t.req = req; t.st = st; t.rs = rs; t.rv = rv; t.rd = rd; t.fl = fl; t.rst = rst;
    t.g = g; t.v = v; t.cv = cv; t.cd = cd; t.o = o; t.fu = fu; t.em = em; t.er = er;
    return t;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int n);
    @(negedge clk);
    reset = t.rst; ch_req = t.req; tx_command_started = t.st; rx_started = t.rs;
    rx_data_valid = t.rv; rx_done = t.rd; flush = t.fl;
    #1;
    check($sformatf("row%0d {grant,valid,rxv,rxd,out,full,empty,err}", n),
          {4'b0, ch_grant, tx_command_valid, ch_rx_valid, ch_rx_done, outstanding, full, empty, error},
          {4'b0, t.g, t.v, t.cv, t.cd, t.o, t.fu, t.em, t.er});
  endtask

  task automatic step(input logic [1:0] rq, input logic st, rs, rv, rd);
    @(negedge clk);
    reset = 1'b0; ch_req = rq; tx_command_started = st; rx_started = rs;
    rx_data_valid = rv; rx_done = rd; flush = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1; ch_req = '0; tx_command_started = 0; rx_started = 0;
    rx_data_valid = 0; rx_done = 0; flush = 0;
    repeat (2) @(negedge clk);

    //            req st rs rv rd fl rst  g  v cv cd o fu em er
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)); // reset state
    // single read
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // two outstanding, full blocks third offer, locked offer survives dropped req
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 1, 1, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // flush releases a locked offer
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // flush mid-reply with two outstanding, then a fresh read routes normally
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    // flush in the same cycle as a push keeps the new entry
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // arbitration with both channels requesting, from a fresh reset
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(3, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(3, 1, 1, 0, 0, 0, 0, R, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(3, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, R, 2, 1, 0, 0));
    tbl.push_back(mk(3, 1, 1, 0, 0, 0, 0, R, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, R, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // reset mid-reply: later beats and rx_done are ignored
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // sticky error, then reset during a locked offer
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // eight-beat reply with a bounded wait for the offer
    step(2'b01, 0, 0, 0, 0);
    n = 0;
    while (!tx_command_valid && n < 8) begin
      step(2'b01, 0, 0, 0, 0);
      n++;
    end
    check("offer_seen", 16'(tx_command_valid), 16'd1);
    step(2'b01, 1, 0, 0, 0);
    check("long_grant", 16'(ch_grant), 16'h1);
    step(2'b00, 0, 0, 0, 0);
    check("long_out1", 16'(outstanding), 16'd1);
    step(2'b00, 0, 1, 0, 0);
    for (int b = 0; b < 8; b++) begin
      step(2'b00, 0, 0, 1, 0);
      check($sformatf("long_beat%0d", b), 16'(ch_rx_valid), 16'h1);
    end
    step(2'b00, 0, 0, 0, 1);
    check("long_done", 16'(ch_rx_done), 16'h1);
    step(2'b00, 0, 0, 0, 0);
    check("long_out0", 16'(outstanding), 16'd0);
    check("long_empty", 16'(empty), 16'd1);

    // header with empty queue in the same cycle as a push: no bypass
    step(2'b01, 1, 1, 0, 0);
    check("nobypass_grant", 16'(ch_grant), 16'h1);
    step(2'b00, 0, 0, 1, 0);
    check("nobypass_error", 16'(error), 16'd1);
    check("nobypass_out", 16'(outstanding), 16'd1);
    check("nobypass_valid", 16'(ch_rx_valid), 16'h0);
    step(2'b00, 0, 1, 0, 0);
    step(2'b00, 0, 0, 1, 0);
    check("late_valid", 16'(ch_rx_valid), 16'h1);
    step(2'b00, 0, 0, 0, 1);
    check("late_done", 16'(ch_rx_done), 16'h1);
    step(2'b00, 0, 0, 0, 0);
    check("late_out0", 16'(outstanding), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
